execute_muldiv: RTL and testbench
=================================

EXECUTE_MULDIV -- requirements
Module: execute_muldiv

Interface
REQ-001 Parameter XLEN, default 32, operand and result width; legal values are 32 and 64.
REQ-002 Parameter MUL_LATENCY, default 2, cycles from accept to multiply result valid; legal range 1..4.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 flush_i  input  1  abort the current operation and discard any pending result.
REQ-006 valid_i  input  1  request valid.
REQ-007 ready_o  output  1  unit can accept a request.
REQ-008 op_i  input  muldiv_op_e  operation: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-009 rs1_i, rs2_i  input  XLEN  operands, already forwarded.
REQ-010 rd_addr_i  input  5  destination register, carried with the operation.
REQ-011 valid_o  output  1  result valid.
REQ-012 ready_i  input  1  consumer accepts the result.
REQ-013 result_o  output  XLEN  result.
REQ-014 rd_addr_o  output  5  destination register of the result.
REQ-015 busy_o  output  1  unit is not IDLE; the hazard unit uses it to stall decode.
REQ-016 illegal_o  output  1  single-cycle pulse when a request is rejected as unsupported.

Function
REQ-017 The unit SHALL implement the FSM states IDLE, MUL, DIV and DONE.
REQ-018 ready_o SHALL equal (state==IDLE) and SHALL be independent of valid_i.
REQ-019 Accept SHALL occur when valid_i, ready_o and !flush_i are all high; on accept the unit SHALL latch op_i, rs1_i, rs2_i and rd_addr_i.
REQ-020 On accept of a multiply, IDLE SHALL go to MUL; valid_o SHALL rise exactly MUL_LATENCY edges after the accept edge.
REQ-021 MUL SHALL return product bits [XLEN-1:0].
REQ-022 MULH, MULHSU and MULHU SHALL return product bits [2*XLEN-1:XLEN], with operand signedness signed×signed, signed×unsigned and unsigned×unsigned respectively.
REQ-023 DIV and REM SHALL use restoring division on operand magnitudes, one quotient bit per cycle, XLEN iterations, followed by one sign-correction cycle.
REQ-024 valid_o for a division SHALL rise XLEN+2 edges after the accept edge.
REQ-025 Divide by zero SHALL bypass iteration, go directly to DONE and give valid_o one edge after accept, with quotient = all ones and remainder = rs1.
REQ-026 Signed overflow (rs1 = most-negative value, rs2 = -1) SHALL bypass iteration, with quotient = rs1 and remainder = 0, valid_o one edge after accept.
REQ-027 Remainder sign SHALL follow the dividend; quotient SHALL truncate toward zero.
REQ-028 In DONE, valid_o SHALL stay high and result_o/rd_addr_o SHALL stay stable until ready_i is high; valid_o and ready_i both high SHALL move the FSM to IDLE.
REQ-029 No new request SHALL be accepted in the same cycle as the DONE handshake.
REQ-030 flush_i high in any state SHALL force IDLE at the next edge and deassert valid_o.
REQ-031 flush_i SHALL take priority over both accept and the DONE handshake.
REQ-032 valid_i asserted while busy SHALL be ignored and SHALL cause no state change.

Reset
REQ-033 When rstn_i is low, the FSM SHALL be IDLE and the iteration counter 0.
REQ-034 During reset valid_o, illegal_o and busy_o SHALL be 0, result_o SHALL be '0, rd_addr_o SHALL be 0, and ready_o SHALL be 1 (state is IDLE).
REQ-035 Reset asserted mid-operation SHALL discard the operation with no output pulse.

Configuration
REQ-036 Macro MULDIV_DIV_EN defined: divide and remainder ops SHALL behave as specified above.
REQ-037 Macro MULDIV_DIV_EN undefined: the divider SHALL be absent; DIV, DIVU, REM and REMU SHALL not be accepted as operations, SHALL pulse illegal_o for one cycle and SHALL leave the FSM in IDLE with valid_o low.

Structure
REQ-038 muldiv_op_e and the state enum SHALL live in riscv_pkg; XLEN SHALL remain a package constant, overridable by the parameter.
REQ-039 The iterative divider SHALL be the sub-module muldiv_divider, with start/done handshake and unsigned magnitudes in and quotient/remainder out; it SHALL be instantiated only under MULDIV_DIV_EN.
REQ-040 The multiplier SHALL be a MUL_LATENCY-deep register pipeline inside execute_muldiv.

Verification (XLEN=32, MUL_LATENCY=2)
REQ-041 MULH, 0x80000000 × 0x80000000 -> 0x40000000, valid_o 2 cycles after accept.
REQ-042 DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF, each with valid_o 34 cycles after accept.
REQ-043 DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each 1 cycle after accept; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM of the same -> 0.
REQ-044 ready_i held low 5 cycles in DONE -> valid_o, result_o and rd_addr_o constant throughout; ready_i high -> IDLE next cycle, ready_o high.
REQ-045 flush_i pulsed at iteration 10 of DIV -> IDLE next cycle, no valid_o; a new MUL 3×4 -> 12 completes normally.
REQ-046 MULDIV_DIV_EN undefined, DIV issued -> illegal_o pulses one cycle, valid_o stays 0, ready_o stays 1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the execute-stage multiply/divide unit: operation codes, FSM states, default XLEN.
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } muldiv_state_e;

   // Upper half of the opcode space is the divide family.
   function automatic logic op_is_div(input muldiv_op_e op);
      return op[2];
   endfunction

   function automatic logic op_is_signed_div(input muldiv_op_e op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic op_is_rem(input muldiv_op_e op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per cycle, XLEN cycles,
// done_o pulses for one cycle once quotient_o/remainder_o are final.
module muldiv_divider #(
   parameter int unsigned XLEN = riscv_pkg::XLEN
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   input  logic            abort_i,
   input  logic            start_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic            done_o,
   output logic [XLEN-1:0] quotient_o,
   output logic [XLEN-1:0] remainder_o
);

   localparam int unsigned CNT_W = $clog2(XLEN + 1);

   logic [CNT_W-1:0] iter_q;
   logic             busy_q;
   logic [XLEN-1:0]  quo_q;
   logic [XLEN-1:0]  rem_q;
   logic [XLEN-1:0]  dvs_q;
   logic [XLEN:0]    shifted_c;
   logic [XLEN:0]    trial_c;

   // Partial remainder shifted left by one with the next dividend bit, and its trial subtraction.
   assign shifted_c = {rem_q, quo_q[XLEN-1]};
   assign trial_c   = shifted_c - {1'b0, dvs_q};

   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin : div_ff
      if (!rstn_i) begin
         iter_q <= '0;
         busy_q <= 1'b0;
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         done_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (abort_i) begin
            busy_q <= 1'b0;
            iter_q <= '0;
         end else if (start_i) begin
            quo_q  <= dividend_i;
            rem_q  <= '0;
            dvs_q  <= divisor_i;
            iter_q <= CNT_W'(XLEN);
            busy_q <= 1'b1;
         end else if (busy_q) begin
            if (trial_c[XLEN]) begin
               rem_q <= shifted_c[XLEN-1:0];
               quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end else begin
               rem_q <= trial_c[XLEN-1:0];
               quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end
            iter_q <= iter_q - CNT_W'(1);
            if (iter_q == CNT_W'(1)) begin
               busy_q <= 1'b0;
               done_o <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/execute_muldiv.sv
// Execute-stage multiply/divide unit with valid/ready request and result handshakes.
// Divide/remainder support is built only when MULDIV_DIV_EN is defined; otherwise those ops pulse illegal_o.
module execute_muldiv #(
   parameter int unsigned XLEN        = riscv_pkg::XLEN,
   parameter int unsigned MUL_LATENCY = 2
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  flush_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  riscv_pkg::muldiv_op_e op_i,
   input  logic [XLEN-1:0]       rs1_i,
   input  logic [XLEN-1:0]       rs2_i,
   input  logic [4:0]            rd_addr_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [XLEN-1:0]       result_o,
   output logic [4:0]            rd_addr_o,
   output logic                  busy_o,
   output logic                  illegal_o
);

   import riscv_pkg::*;

   localparam int unsigned CNT_W = 3;

   muldiv_state_e    state_q;
   logic [CNT_W-1:0] mul_cnt_q;
   logic [4:0]       rd_q;
   logic [XLEN-1:0]  mul_pipe_q [MUL_LATENCY];

   logic             accept_c;
   logic             is_div_c;
   logic             a_sgn_c;
   logic             b_sgn_c;
   logic [2*XLEN-1:0] a_ext_c;
   logic [2*XLEN-1:0] b_ext_c;
   logic [2*XLEN-1:0] prod_c;
   logic [XLEN-1:0]  mul_res_c;

   assign ready_o  = (state_q == ST_IDLE);
   assign busy_o   = !ready_o;
   assign accept_c = valid_i && ready_o && !flush_i;
   assign is_div_c = op_is_div(op_i);

   // Sign-extend to 2*XLEN so one unsigned multiply yields all three high-half signedness variants.
   assign a_sgn_c   = ((op_i == OP_MULH) || (op_i == OP_MULHSU)) && rs1_i[XLEN-1];
   assign b_sgn_c   = (op_i == OP_MULH) && rs2_i[XLEN-1];
   assign a_ext_c   = {{XLEN{a_sgn_c}}, rs1_i};
   assign b_ext_c   = {{XLEN{b_sgn_c}}, rs2_i};
   assign prod_c    = a_ext_c * b_ext_c;
   assign mul_res_c = (op_i == OP_MUL) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];

   // Product pipeline: stage 0 captured at accept, result taken from the last stage.
   always_ff @(posedge clk_i or negedge rstn_i) begin : mul_pipe_ff
      if (!rstn_i) begin
         for (int i = 0; i < int'(MUL_LATENCY); i++) mul_pipe_q[i] <= '0;
      end else begin
         if (accept_c && !is_div_c) mul_pipe_q[0] <= mul_res_c;
         for (int i = 1; i < int'(MUL_LATENCY); i++) mul_pipe_q[i] <= mul_pipe_q[i-1];
      end
   end

`ifdef MULDIV_DIV_EN
   logic            signed_c;
   logic            rem_c;
   logic            a_neg_c;
   logic            b_neg_c;
   logic            div0_c;
   logic            ovf_c;
   logic            div_start_c;
   logic [XLEN-1:0] a_mag_c;
   logic [XLEN-1:0] b_mag_c;
   logic [XLEN-1:0] bypass_res_c;
   logic            div_done;
   logic [XLEN-1:0] div_quo;
   logic [XLEN-1:0] div_rem;
   logic            q_neg_q;
   logic            r_neg_q;
   logic            is_rem_q;
   logic            fix_q;
   logic [XLEN-1:0] fix_res_q;

   assign signed_c = op_is_signed_div(op_i);
   assign rem_c    = op_is_rem(op_i);
   assign a_neg_c  = signed_c && rs1_i[XLEN-1];
   assign b_neg_c  = signed_c && rs2_i[XLEN-1];
   assign a_mag_c  = a_neg_c ? -rs1_i : rs1_i;
   assign b_mag_c  = b_neg_c ? -rs2_i : rs2_i;
   assign div0_c   = (rs2_i == '0);
   assign ovf_c    = signed_c && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);

   // Divide-by-zero and signed overflow skip the iteration with a fixed result.
   assign div_start_c  = accept_c && is_div_c && !div0_c && !ovf_c;
   assign bypass_res_c = div0_c ? (rem_c ? rs1_i : '1) : (rem_c ? '0 : rs1_i);

   muldiv_divider #(
      .XLEN (XLEN)
   ) u_divider (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .abort_i     (flush_i),
      .start_i     (div_start_c),
      .dividend_i  (a_mag_c),
      .divisor_i   (b_mag_c),
      .done_o      (div_done),
      .quotient_o  (div_quo),
      .remainder_o (div_rem)
   );
`endif

   always_ff @(posedge clk_i or negedge rstn_i) begin : fsm_ff
      if (!rstn_i) begin
         state_q   <= ST_IDLE;
         mul_cnt_q <= '0;
         rd_q      <= '0;
         valid_o   <= 1'b0;
         illegal_o <= 1'b0;
         result_o  <= '0;
         rd_addr_o <= '0;
`ifdef MULDIV_DIV_EN
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         is_rem_q  <= 1'b0;
         fix_q     <= 1'b0;
         fix_res_q <= '0;
`endif
      end else begin
         illegal_o <= 1'b0;
         if (flush_i) begin
            state_q <= ST_IDLE;
            valid_o <= 1'b0;
`ifdef MULDIV_DIV_EN
            fix_q   <= 1'b0;
`endif
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (accept_c) begin
                     rd_q <= rd_addr_i;
                     if (!is_div_c) begin
                        state_q   <= ST_MUL;
                        mul_cnt_q <= '0;
                     end else begin
`ifdef MULDIV_DIV_EN
                        state_q   <= ST_DIV;
                        q_neg_q   <= a_neg_c ^ b_neg_c;
                        r_neg_q   <= a_neg_c;
                        is_rem_q  <= rem_c;
                        fix_q     <= div0_c || ovf_c;
                        fix_res_q <= bypass_res_c;
`else
                        illegal_o <= 1'b1;
`endif
                     end
                  end
               end
               ST_MUL: begin
                  if (mul_cnt_q == CNT_W'(MUL_LATENCY - 1)) begin
                     state_q   <= ST_DONE;
                     valid_o   <= 1'b1;
                     result_o  <= mul_pipe_q[MUL_LATENCY-1];
                     rd_addr_o <= rd_q;
                  end else begin
                     mul_cnt_q <= mul_cnt_q + CNT_W'(1);
                  end
               end
               ST_DIV: begin
`ifdef MULDIV_DIV_EN
                  // fix_q marks a result already sign-corrected (or bypassed) and ready to present.
                  if (fix_q) begin
                     state_q   <= ST_DONE;
                     valid_o   <= 1'b1;
                     result_o  <= fix_res_q;
                     rd_addr_o <= rd_q;
                     fix_q     <= 1'b0;
                  end else if (div_done) begin
                     fix_q     <= 1'b1;
                     fix_res_q <= is_rem_q ? (r_neg_q ? -div_rem : div_rem)
                                           : (q_neg_q ? -div_quo : div_quo);
                  end
`else
                  state_q <= ST_IDLE;
`endif
               end
               ST_DONE: begin
                  if (ready_i) begin
                     state_q <= ST_IDLE;
                     valid_o <= 1'b0;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_execute_muldiv.sv
// Scoreboard bench for execute_muldiv (XLEN=32, MUL_LATENCY=2); divide checks follow MULDIV_DIV_EN.
module tb_execute_muldiv;

   import riscv_pkg::*;

   localparam int MUL_LAT = 2;
   localparam int DIV_LAT = 34;
   localparam int BYP_LAT = 1;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic        flush_i;
   logic        valid_i;
   logic        ready_o;
   muldiv_op_e  op_i;
   logic [31:0] rs1_i;
   logic [31:0] rs2_i;
   logic [4:0]  rd_addr_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] result_o;
   logic [4:0]  rd_addr_o;
   logic        busy_o;
   logic        illegal_o;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   execute_muldiv #(
      .XLEN        (32),
      .MUL_LATENCY (MUL_LAT)
   ) dut (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .flush_i   (flush_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .op_i      (op_i),
      .rs1_i     (rs1_i),
      .rs2_i     (rs2_i),
      .rd_addr_i (rd_addr_i),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .result_o  (result_o),
      .rd_addr_o (rd_addr_o),
      .busy_o    (busy_o),
      .illegal_o (illegal_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mul_ref(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b);
      longint p;
      case (op)
         OP_MUL, OP_MULH: p = longint'(int'(a)) * longint'(int'(b));
         OP_MULHSU:       p = longint'(int'(a)) * longint'({32'b0, b});
         default:         p = longint'({32'b0, a}) * longint'({32'b0, b});
      endcase
      return (op == OP_MUL) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [31:0] div_ref(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b);
      logic ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (b == 32'd0) return (op == OP_REM || op == OP_REMU) ? a : 32'hFFFF_FFFF;
      case (op)
         OP_DIV:  return ovf ? a : 32'(int'(a) / int'(b));
         OP_REM:  return ovf ? 32'd0 : 32'(int'(a) % int'(b));
         OP_DIVU: return a / b;
         default: return a % b;
      endcase
   endfunction

   // Drive one request once the unit is idle; returns #1 after the accept edge.
   task automatic issue(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      int n;
      n = 0;
      while (!ready_o && n < 100) begin
         @(posedge clk_i); #1;
         n++;
      end
      check_eq("issue_ready", ready_o, 1);
      valid_i   = 1'b1;
      op_i      = op;
      rs1_i     = a;
      rs2_i     = b;
      rd_addr_i = rd;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
   endtask

   // Wait (bounded) for valid_o, then pop the scoreboard and compare latency, result and rd.
   task automatic collect(input string tag);
      exp_t e;
      int   lat;
      lat = 0;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk_i); #1;
         if (valid_o) begin
            lat = k;
            break;
         end
      end
      e = sb.pop_front();
      check_eq({tag, "_lat"}, lat, e.lat);
      check_eq({tag, "_res"}, result_o, e.res);
      check_eq({tag, "_rd"}, rd_addr_o, e.rd);
   endtask

   task automatic run_op(input string tag, input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res, input int lat);
      exp_t e;
      e.res = res;
      e.rd  = rd;
      e.lat = lat;
      sb.push_back(e);
      issue(op, a, b, rd);
      collect(tag);
   endtask

   initial begin
      logic [31:0] a, b, r_snap;
      logic [4:0]  rd_snap;
      logic        stable, saw_valid;
      muldiv_op_e  op;

      rstn_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
      op_i = OP_MUL; rs1_i = '0; rs2_i = '0; rd_addr_i = '0;

      #12;
      check_eq("rst_ready", ready_o, 1);
      check_eq("rst_valid", valid_o, 0);
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_illegal", illegal_o, 0);
      check_eq("rst_result", result_o, 0);
      check_eq("rst_rd", rd_addr_o, 0);
      @(posedge clk_i); #1;
      rstn_i = 1'b1;
      @(posedge clk_i); #1;

      run_op("mulh_min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, MUL_LAT);
      run_op("mul_3x4", OP_MUL, 32'd3, 32'd4, 5'd2, 32'd12, MUL_LAT);
      run_op("mul_neg", OP_MUL, 32'hFFFF_FFFD, 32'd5, 5'd3, 32'hFFFF_FFF1, MUL_LAT);
      run_op("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, MUL_LAT);
      run_op("mulhsu_m1", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF, MUL_LAT);
      run_op("mulh_pos", OP_MULH, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd6, 32'h3FFF_FFFF, MUL_LAT);
      for (int i = 0; i < 6; i++) begin
         op = muldiv_op_e'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         run_op("mul_rand", op, a, b, 5'(i + 8), mul_ref(op, a, b), MUL_LAT);
      end

      // Requests presented while busy must be ignored.
      issue(OP_MUL, 32'd6, 32'd7, 5'd11);
      valid_i = 1'b1; op_i = OP_MULHU; rs1_i = 32'd9; rs2_i = 32'd9; rd_addr_i = 5'd22;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      check_eq("busy_ign_busy", busy_o, 1);
      check_eq("busy_ign_nov", valid_o, 0);
      @(posedge clk_i); #1;
      check_eq("busy_ign_valid", valid_o, 1);
      check_eq("busy_ign_res", result_o, 32'd42);
      check_eq("busy_ign_rd", rd_addr_o, 5'd11);
      @(posedge clk_i); #1;
      check_eq("busy_ign_idle", ready_o, 1);
      check_eq("busy_ign_novalid", valid_o, 0);

      // Result held while the consumer stalls.
      ready_i = 1'b0;
      run_op("bp_mul", OP_MUL, 32'h1234, 32'h10, 5'd7, 32'h12340, MUL_LAT);
      r_snap = result_o; rd_snap = rd_addr_o; stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_i); #1;
         if (!valid_o || result_o !== r_snap || rd_addr_o !== rd_snap || ready_o) stable = 1'b0;
      end
      check_eq("bp_hold", stable, 1);
      check_eq("bp_busy", busy_o, 1);
      ready_i = 1'b1;
      @(posedge clk_i); #1;
      check_eq("bp_release_valid", valid_o, 0);
      check_eq("bp_release_ready", ready_o, 1);

`ifdef MULDIV_DIV_EN
      run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFD, DIV_LAT);
      run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'hFFFF_FFFF, DIV_LAT);
      run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, BYP_LAT);
      run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 5'd15, 32'd5, BYP_LAT);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, BYP_LAT);
      run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, BYP_LAT);
      run_op("rem_m5_0", OP_REM, 32'hFFFF_FFFB, 32'd0, 5'd18, 32'hFFFF_FFFB, BYP_LAT);
      run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd19, 32'd14, DIV_LAT);
      run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd20, 32'd2, DIV_LAT);
      run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd21, 32'd1, DIV_LAT);
      run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd22, 32'hFFFF_FFFF, DIV_LAT);
      for (int i = 0; i < 6; i++) begin
         op = muldiv_op_e'($urandom_range(4, 7));
         a  = $urandom;
         b  = $urandom_range(1, 5000);
         if ($urandom_range(0, 1) == 1) b = -b;
         run_op("div_rand", op, a, b, 5'(i + 24), div_ref(op, a, b), DIV_LAT);
      end

      // Flush in the middle of the iteration.
      issue(OP_DIV, 32'd1000, 32'd3, 5'd3);
      repeat (10) @(posedge clk_i);
      #1 flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0;
`else
      issue(OP_DIV, 32'd7, 32'd2, 5'd9);
      check_eq("ill_pulse", illegal_o, 1);
      check_eq("ill_valid", valid_o, 0);
      check_eq("ill_ready", ready_o, 1);
      @(posedge clk_i); #1;
      check_eq("ill_pulse_end", illegal_o, 0);
      check_eq("ill_valid2", valid_o, 0);
      check_eq("ill_ready2", ready_o, 1);

      // Flush while the multiply is in flight.
      issue(OP_MUL, 32'd5, 32'd5, 5'd3);
      flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0;
`endif
      check_eq("flush_ready", ready_o, 1);
      check_eq("flush_busy", busy_o, 0);
      saw_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_i); #1;
         if (valid_o) saw_valid = 1'b1;
      end
      check_eq("flush_no_valid", saw_valid, 0);
      run_op("post_flush_mul", OP_MUL, 32'd3, 32'd4, 5'd10, 32'd12, MUL_LAT);

      // Reset mid-operation drops the result.
      issue(OP_MUL, 32'd2, 32'd2, 5'd9);
      rstn_i = 1'b0;
      #2;
      check_eq("midrst_busy", busy_o, 0);
      check_eq("midrst_valid", valid_o, 0);
      @(posedge clk_i); #1;
      rstn_i = 1'b1;
      saw_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk_i); #1;
         if (valid_o) saw_valid = 1'b1;
      end
      check_eq("midrst_no_valid", saw_valid, 0);
      run_op("post_rst_mul", OP_MULHU, 32'h0001_0000, 32'h0003_0000, 5'd31, 32'd3, MUL_LAT);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
